led_pwm_driver: RTL
===================

# led_pwm_driver

Output stage between the APB LED control register and the board LED pins. It takes the 8-bit on/off word from the register block and drives each LED with a programmable PWM brightness. It also provides optional per-channel linear fade-in/fade-out and a global blink gate. All updates are aligned to PWM frame boundaries so the pins never glitch.

## Interface
- CLK_DIV, 50: PCLK cycles per PWM tick; legal range 1..65535.
- FADE_STEP, 4: level change per PWM frame while fading; legal range 1..255.
- PCLK  in  1  system clock; the only clock in the block.
- PRESET  in  1  reset, synchronous and active-high.
- LED_IN  in  8  per-channel on request, taken from the LED control register output.
- BRIGHT  in  8  target duty for channels that are on; 0 = dark, 255 = max.
- FADE_EN  in  1  1 = ramp levels by FADE_STEP per frame; 0 = jump to the target level.
- BLINK_EN  in  1  1 = gate all outputs with the blink phase.
- BLINK_HALF  in  8  blink half-period in PWM frames; a value of 0 is treated as 1.
- LED_OUT  out  8  pin drive, registered, active-high.
- FRAME  out  1  one-cycle pulse in the cycle after each frame start.
- BUSY  out  1  1 while any channel level differs from its target.

## Operation
- **Prescaler:** 16-bit counter `div` runs 0..CLK_DIV-1 and wraps to 0. `tick` = (div == CLK_DIV-1).
- **PWM counter:** 8-bit `pwm` increments on `tick` and wraps 255 -> 0. A frame is 256 ticks (256*CLK_DIV PCLK cycles).
- **Frame start:** `fs` = tick & (pwm == 255). LED_IN, BRIGHT, FADE_EN and BLINK_HALF are sampled only on `fs`. Changes between frame starts have no effect until the next `fs`.
- **Per-channel target:** tgt[i] = LED_IN[i] ? BRIGHT : 0.
- **Level update on `fs`, FADE_EN=0:** lvl[i] <= tgt[i].
- **Level update on `fs`, FADE_EN=1:**
  - if lvl < tgt: lvl <= min(lvl+FADE_STEP, tgt);
  - if lvl > tgt: lvl <= max(lvl-FADE_STEP, tgt);
  - arithmetic is 9-bit internally; lvl never overshoots the target and never wraps.
- **Target change mid-fade:** the fade continues from the current lvl toward the new tgt, with no restart.
- **Blink, BLINK_EN=1:**
  - 8-bit frame counter `bcnt` increments on `fs`.
  - When bcnt reaches max(BLINK_HALF,1)-1, bcnt <= 0 and `phase` toggles.
- **Blink, BLINK_EN=0:** bcnt held at 0 and phase forced to 1.
- Blink never alters lvl; fades continue while blinked off.
- **Pin drive:** each cycle, LED_OUT[i] <= phase & (pwm < lvl[i]).
  - lvl=0: output always 0.
  - lvl=255: output high 255 of 256 ticks.
- **FRAME:** registered copy of `fs`.
- **BUSY:** combinational OR over i of (lvl[i] != tgt[i]), using the current LED_IN/BRIGHT. It may assert between frames before the new target is sampled.

## Timing
- **Reset:** div=0, pwm=0, lvl=0, bcnt=0, phase=1, LED_OUT=0, FRAME=0. BUSY is 0 if LED_IN=0, else 1.
- **Reset mid-fade or mid-blink:** all state returns to the reset values on the next PCLK edge; no partial fade survives.
- **First frame start:** occurs 256*CLK_DIV cycles after reset release.
- **Latency:** a new level takes effect on LED_OUT one cycle after the `fs` edge.
- **Fade duration:** full fade 0 -> 255 takes ceil(255/FADE_STEP) frames.
- **Simultaneous events:**
  - `fs` coincident with a blink toggle: both apply on the same edge.
  - LED_IN change on the `fs` cycle itself: sampled (it counts as that frame's value).
- **CLK_DIV=1:** tick every cycle and `fs` every 256 cycles; behaviour is otherwise identical.

## Test plan
- CLK_DIV=4, FADE_EN=0, BRIGHT=128, LED_IN=0x01 -> after the first frame start, LED_OUT[0] is high for exactly 128 ticks (512 cycles) per 1024-cycle frame; other bits stay 0; FRAME pulses every 1024 cycles.
- FADE_EN=1, FADE_STEP=4, BRIGHT=255, LED_IN 0x00 -> 0xFF:
  - lvl goes 4, 8, … 252, 255 over 64 frames;
  - BUSY drops in the frame-64 update cycle;
  - then LED_IN -> 0x00 ramps back down to 0 in 64 frames.
- Mid-fade at lvl=100, change BRIGHT to 50 -> lvl steps 96, 92 … 52, 50 with no overshoot, then holds.
- BLINK_EN=1, BLINK_HALF=3, BRIGHT=255, LED_IN=0xFF -> LED_OUT is all-zero for 3 frames, PWM-active for 3 frames, repeating. With BLINK_HALF=0 it alternates every frame.
- Assert PRESET for 1 cycle mid-fade at lvl=60 -> the next cycle shows LED_OUT=0, FRAME=0, phase=1. The fade restarts from 0 at the first frame start 1024 cycles later.
- Toggle LED_IN within a frame and restore it before `fs` -> LED_OUT waveform is unchanged; BUSY pulses only during the toggle.

Source files
------------

// File: rtl/led_pwm_driver.sv
// Frame-aligned PWM output stage for eight board LEDs, with optional linear
// per-channel fading and a global blink gate applied on top of the PWM.
module led_pwm_driver #(
    parameter int unsigned CLK_DIV   = 50,
    parameter int unsigned FADE_STEP = 4
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic [7:0] LED_IN,
    input  logic [7:0] BRIGHT,
    input  logic       FADE_EN,
    input  logic       BLINK_EN,
    input  logic [7:0] BLINK_HALF,
    output logic [7:0] LED_OUT,
    output logic       FRAME,
    output logic       BUSY
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [8:0]  STEP     = 9'(FADE_STEP);

    logic [15:0] div_q, div_d;
    logic [7:0]  pwm_q, pwm_d;
    logic [7:0]  lvl_q [8];
    logic [7:0]  lvl_d [8];
    logic [7:0]  tgt   [8];
    logic [8:0]  up_s  [8];
    logic [8:0]  dn_s  [8];
    logic [7:0]  bcnt_q, bcnt_d;
    logic        phase_q, phase_d;
    logic [7:0]  led_q, led_d;
    logic        frame_q;
    logic        tick;
    logic        fs;
    logic [7:0]  half_last;

    assign tick      = (div_q == DIV_LAST);
    assign fs        = tick && (pwm_q == 8'hFF);
    assign half_last = (BLINK_HALF == 8'd0) ? 8'd0 : BLINK_HALF - 8'd1;

    always_comb begin
        div_d = tick ? 16'd0 : div_q + 16'd1;
        pwm_d = tick ? pwm_q + 8'd1 : pwm_q;
    end

    // Fade arithmetic is 9 bits wide so the clamp sees overflow and underflow.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        BUSY = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tgt[i]   = LED_IN[i] ? BRIGHT : 8'd0;
            up_s[i]  = {1'b0, lvl_q[i]} + STEP;
            dn_s[i]  = {1'b0, lvl_q[i]} - STEP;
            lvl_d[i] = lvl_q[i];
            BUSY     = BUSY | (lvl_q[i] != tgt[i]);
            if (fs) begin
                if (!FADE_EN) begin
                    lvl_d[i] = tgt[i];
                end else if (lvl_q[i] < tgt[i]) begin
                    lvl_d[i] = (up_s[i] > {1'b0, tgt[i]}) ? tgt[i] : up_s[i][7:0];
                end else if (lvl_q[i] > tgt[i]) begin
                    lvl_d[i] = (dn_s[i][8] || (dn_s[i][7:0] < tgt[i])) ? tgt[i] : dn_s[i][7:0];
                end
            end
        end
    end

    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (!BLINK_EN) begin
            bcnt_d  = 8'd0;
            phase_d = 1'b1;
        end else if (fs) begin
            if (bcnt_q >= half_last) begin
                bcnt_d  = 8'd0;
                phase_d = !phase_q;
            end else begin
                bcnt_d = bcnt_q + 8'd1;
            end
        end
        for (int i = 0; i < 8; i++) begin
            led_d[i] = phase_q && (pwm_q < lvl_q[i]);
        end
    end

    // NOTE: state uses non-blocking assignments so every flop updates together at the edge.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            div_q   <= 16'd0;
            pwm_q   <= 8'd0;
            bcnt_q  <= 8'd0;
            phase_q <= 1'b1;
            led_q   <= 8'd0;
            frame_q <= 1'b0;
            // NOTE: lvl_q is a small register array rather than a RAM, so it is reset with the rest.
            for (int i = 0; i < 8; i++) begin
                lvl_q[i] <= 8'd0;
            end
        end else begin
            div_q   <= div_d;
            pwm_q   <= pwm_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            led_q   <= led_d;
            frame_q <= fs;
            for (int i = 0; i < 8; i++) begin
                lvl_q[i] <= lvl_d[i];
            end
        end
    end

    assign LED_OUT = led_q;
    assign FRAME   = frame_q;

endmodule
